// File: rtl/clock12_setter.sv
// Time-setting front end for the 12-hour clock: snapshot, edit hours/minutes/AM-PM, commit with a one-cycle propagate.
// Optional auto-repeat of held up/down buttons is enabled with `define AUTO_REPEAT_EN.
module clock12_setter #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int BLINK_CYCLES   = 250,
  parameter int REPEAT_DELAY   = 300,
  parameter int REPEAT_RATE    = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       cur_PM,
  input  logic [3:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic       propagate,
  output logic       out_PM,
  output logic [3:0] out_hours,
  output logic [5:0] out_minutes,
  output logic       editing,
  output logic [1:0] edit_field,
  output logic       blink
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(BLINK_CYCLES + 1);

  // The repeat counter reloads to REPEAT_DELAY - REPEAT_RATE + 1, so the rate must fit inside the delay.
  if (REPEAT_RATE < 1 || REPEAT_RATE > REPEAT_DELAY + 1) begin : g_bad_repeat
    $error("clock12_setter: REPEAT_RATE must be in 1..REPEAT_DELAY+1");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_HOUR,
    S_MIN,
    S_AMPM,
    S_COMMIT
  } state_t;

  state_t          state, state_next;
  logic            mode_q, up_q, down_q;
  logic            mode_ev, up_ev, down_ev;
  logic            rep_up, rep_down;
  logic [TW-1:0]   idle_cnt;
  logic [BW-1:0]   blink_cnt;
  logic            in_edit, any_ev, timeout, inc, dec;

  assign inc    = (up_ev | rep_up) & ~(down_ev | rep_down);
  assign dec    = (down_ev | rep_down) & ~(up_ev | rep_up);
  assign any_ev = mode_ev | up_ev | down_ev | rep_up | rep_down;

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  logic [RW-1:0] rep_cnt;
  logic          rep_hold, rep_fire;

  // Exactly one of up/down held in a numeric field keeps the repeat counter running.
  assign rep_hold = (state == S_HOUR || state == S_MIN) && (btn_up ^ btn_down);
  assign rep_fire = rep_hold && (rep_cnt == RW'(REPEAT_DELAY));
  assign rep_up   = rep_fire & btn_up;
  assign rep_down = rep_fire & btn_down;

  always_ff @(posedge clk) begin
    if (reset || !rep_hold) rep_cnt <= '0;
    else if (rep_fire)      rep_cnt <= RW'(REPEAT_DELAY - REPEAT_RATE + 1);
    else                    rep_cnt <= rep_cnt + 1'b1;
  end
`else
  assign rep_up   = 1'b0;
  assign rep_down = 1'b0;
`endif

  // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
  always_comb begin
    state_next = state;
    editing    = 1'b0;
    edit_field = 2'd0;
    propagate  = 1'b0;
    in_edit    = 1'b0;
    case (state)
      S_IDLE:   if (mode_ev) state_next = S_HOUR;
      S_HOUR: begin
        editing    = 1'b1;
        edit_field = 2'd1;
        in_edit    = 1'b1;
      end
      S_MIN: begin
        editing    = 1'b1;
        edit_field = 2'd2;
        in_edit    = 1'b1;
      end
      S_AMPM: begin
        editing    = 1'b1;
        edit_field = 2'd3;
        in_edit    = 1'b1;
      end
      S_COMMIT: begin
        propagate  = 1'b1;
        state_next = S_IDLE;
      end
      default:  state_next = S_IDLE;
    endcase
    timeout = in_edit && !any_ev && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));
    if (in_edit) begin
      if (mode_ev)      state_next = state_t'(state + 3'd1);
      else if (timeout) state_next = S_IDLE;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      mode_q      <= 1'b0;
      up_q        <= 1'b0;
      down_q      <= 1'b0;
      mode_ev     <= 1'b0;
      up_ev       <= 1'b0;
      down_ev     <= 1'b0;
      idle_cnt    <= '0;
      blink_cnt   <= '0;
      blink       <= 1'b0;
      out_PM      <= 1'b0;
      out_hours   <= 4'd0;
      out_minutes <= 6'd0;
    end else begin
      state   <= state_next;
      mode_q  <= btn_mode;
      up_q    <= btn_up;
      down_q  <= btn_down;
      mode_ev <= btn_mode & ~mode_q;
      up_ev   <= btn_up & ~up_q;
      down_ev <= btn_down & ~down_q;

      idle_cnt <= (in_edit && !any_ev) ? idle_cnt + 1'b1 : '0;

      if (!in_edit) begin
        blink_cnt <= '0;
        blink     <= 1'b0;
      end else if (blink_cnt == BW'(BLINK_CYCLES - 1)) begin
        blink_cnt <= '0;
        blink     <= ~blink;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end

      // A mode event always wins over simultaneous value steps.
      if (state == S_IDLE && mode_ev) begin
        out_PM      <= cur_PM;
        out_hours   <= (cur_hours == 4'd0 || cur_hours > 4'd12) ? 4'd12 : cur_hours;
        out_minutes <= (cur_minutes > 6'd59) ? 6'd0 : cur_minutes;
      end else if (!mode_ev) begin
        case (state)
          S_HOUR: begin
            if (inc)      out_hours <= (out_hours >= 4'd12) ? 4'd1 : out_hours + 4'd1;
            else if (dec) out_hours <= (out_hours <= 4'd1) ? 4'd12 : out_hours - 4'd1;
          end
          S_MIN: begin
            if (inc)      out_minutes <= (out_minutes >= 6'd59) ? 6'd0 : out_minutes + 6'd1;
            else if (dec) out_minutes <= (out_minutes == 6'd0) ? 6'd59 : out_minutes - 6'd1;
          end
          S_AMPM:  if (up_ev ^ down_ev) out_PM <= ~out_PM;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_clock12_setter.sv
// Self-checking bench for clock12_setter: directed vector table, timeout/blink/reset sequences,
// and randomized button presses against a field-level reference model.
module tb_clock12_setter;

  localparam int TO = 20;
  localparam int BL = 4;
  localparam int RD = 10;
  localparam int RR = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_up, btn_down;
  logic       cur_PM;
  logic [3:0] cur_hours;
  logic [5:0] cur_minutes;
  logic       propagate, out_PM, editing, blink;
  logic [3:0] out_hours;
  logic [5:0] out_minutes;
  logic [1:0] edit_field;

  clock12_setter #(
    .TIMEOUT_CYCLES(TO),
    .BLINK_CYCLES  (BL),
    .REPEAT_DELAY  (RD),
    .REPEAT_RATE   (RR)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_mode   (btn_mode),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .cur_PM     (cur_PM),
    .cur_hours  (cur_hours),
    .cur_minutes(cur_minutes),
    .propagate  (propagate),
    .out_PM     (out_PM),
    .out_hours  (out_hours),
    .out_minutes(out_minutes),
    .editing    (editing),
    .edit_field (edit_field),
    .blink      (blink)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int prop_cnt = 0;
  int cap_h, cap_m, cap_pm;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Propagate monitor: counts pulses, captures the committed value, rejects back-to-back pulses.
  initial begin
    logic prev = 1'b0;
    forever begin
      @(negedge clk);
      if (propagate) begin
        check("prop_single_cycle", int'(prev), 0);
        prop_cnt++;
        cap_h  = int'(out_hours);
        cap_m  = int'(out_minutes);
        cap_pm = int'(out_PM);
      end
      prev = propagate;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1, "watchdog");
  end

  task automatic press(input bit m, input bit u, input bit d, input int len, input int gap);
    btn_mode = m;
    btn_up   = u;
    btn_down = d;
    repeat (len) @(negedge clk);
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic set_cur(input bit pm, input int h, input int m);
    cur_PM      = pm;
    cur_hours   = 4'(h);
    cur_minutes = 6'(m);
  endtask

  typedef struct {
    bit m, u, d;
    bit cpm;
    int ch, cm;
    int f, h, mi, pm;
    int prop;
  } vec_t;

  // Reference model state: which field is being edited and the value being built.
  int mf, mh, mm, mpm, exp_prop;

  function automatic int snap_h(input int h);
    return (h == 0 || h > 12) ? 12 : h;
  endfunction

  task automatic model_press(input bit m, input bit u, input bit d);
    if (mf == 0) begin
      if (m) begin
        mh  = snap_h(int'(cur_hours));
        mm  = (int'(cur_minutes) > 59) ? 0 : int'(cur_minutes);
        mpm = int'(cur_PM);
        mf  = 1;
      end
    end else if (m) begin
      if (mf == 3) begin
        mf = 0;
        exp_prop++;
      end else begin
        mf++;
      end
    end else if (u ^ d) begin
      case (mf)
        1: mh  = u ? (mh % 12) + 1 : ((mh + 10) % 12) + 1;
        2: mm  = u ? (mm + 1) % 60 : (mm + 59) % 60;
        3: mpm = 1 - mpm;
        default: ;
      endcase
    end
  endtask

  initial begin
    vec_t vecs[$];
    int   p0;

    reset    = 1'b1;
    btn_mode = 1'b0;
    btn_up   = 1'b0;
    btn_down = 1'b0;
    set_cur(0, 0, 0);
    do_reset();

    check("rst_propagate", int'(propagate), 0);
    check("rst_editing", int'(editing), 0);
    check("rst_field", int'(edit_field), 0);
    check("rst_blink", int'(blink), 0);
    check("rst_hours", int'(out_hours), 0);
    check("rst_minutes", int'(out_minutes), 0);
    check("rst_pm", int'(out_PM), 0);

    //           m  u  d  cpm ch  cm  f  h   mi  pm prop
    vecs.push_back('{1, 0, 0, 0, 0, 0, 1, 12, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 2, 12, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 3, 12, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, 12, 0, 0, 1});
    vecs.push_back('{0, 1, 0, 1, 5, 5, 0, 12, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 11, 58, 1, 11, 58, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 11, 58, 1, 12, 58, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 11, 58, 2, 12, 58, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 11, 58, 2, 12, 59, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 11, 58, 2, 12, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 11, 58, 3, 12, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 0, 11, 58, 3, 12, 0, 1, 0});
    vecs.push_back('{1, 0, 0, 0, 11, 58, 0, 12, 0, 1, 1});
    vecs.push_back('{1, 0, 0, 1, 1, 0, 1, 1, 0, 1, 0});
    vecs.push_back('{0, 0, 1, 1, 1, 0, 1, 12, 0, 1, 0});
    vecs.push_back('{0, 1, 0, 1, 1, 0, 1, 1, 0, 1, 0});
    vecs.push_back('{0, 1, 1, 1, 1, 0, 1, 1, 0, 1, 0});
    vecs.push_back('{1, 1, 0, 1, 1, 0, 2, 1, 0, 1, 0});
    vecs.push_back('{0, 0, 1, 1, 1, 0, 2, 1, 59, 1, 0});
    vecs.push_back('{0, 1, 1, 1, 1, 0, 2, 1, 59, 1, 0});
    vecs.push_back('{1, 0, 1, 1, 1, 0, 3, 1, 59, 1, 0});
    vecs.push_back('{0, 0, 1, 1, 1, 0, 3, 1, 59, 0, 0});
    vecs.push_back('{0, 1, 1, 1, 1, 0, 3, 1, 59, 0, 0});
    vecs.push_back('{1, 0, 0, 1, 1, 0, 0, 1, 59, 0, 1});
    vecs.push_back('{1, 0, 0, 0, 15, 63, 1, 12, 0, 0, 0});
    vecs.push_back('{1, 0, 0, 0, 13, 60, 2, 12, 0, 0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      set_cur(vecs[i].cpm, vecs[i].ch, vecs[i].cm);
      p0 = prop_cnt;
      press(vecs[i].m, vecs[i].u, vecs[i].d, 1, 3);
      check($sformatf("vec%0d_field", i), int'(edit_field), vecs[i].f);
      check($sformatf("vec%0d_editing", i), int'(editing), int'(vecs[i].f != 0));
      check($sformatf("vec%0d_hours", i), int'(out_hours), vecs[i].h);
      check($sformatf("vec%0d_minutes", i), int'(out_minutes), vecs[i].mi);
      check($sformatf("vec%0d_pm", i), int'(out_PM), vecs[i].pm);
      check($sformatf("vec%0d_prop", i), prop_cnt - p0, vecs[i].prop);
      if (vecs[i].prop != 0) begin
        check($sformatf("vec%0d_cap_h", i), cap_h, vecs[i].h);
        check($sformatf("vec%0d_cap_m", i), cap_m, vecs[i].mi);
        check($sformatf("vec%0d_cap_pm", i), cap_pm, vecs[i].pm);
      end
    end

    // Reset in the middle of AM/PM editing.
    do_reset();
    set_cur(1, 5, 30);
    press(1, 0, 0, 1, 3);
    press(1, 0, 0, 1, 3);
    press(1, 0, 0, 1, 3);
    check("pre_rst_field", int'(edit_field), 3);
    p0 = prop_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_field", int'(edit_field), 0);
    check("midrst_editing", int'(editing), 0);
    check("midrst_hours", int'(out_hours), 0);
    check("midrst_minutes", int'(out_minutes), 0);
    check("midrst_pm", int'(out_PM), 0);
    check("midrst_blink", int'(blink), 0);
    check("midrst_prop_now", int'(propagate), 0);
    repeat (3) @(negedge clk);
    check("midrst_no_prop", prop_cnt - p0, 0);

    // Blink half-period while editing hours.
    begin
      int   waited = 0, width = 0;
      logic b0;
      set_cur(0, 4, 4);
      press(1, 0, 0, 1, 2);
      b0 = blink;
      while (blink == b0 && waited < 3 * BL) begin
        @(negedge clk);
        waited++;
      end
      check("blink_first_toggle", int'(blink != b0), 1);
      b0 = blink;
      while (blink == b0 && width < 3 * BL) begin
        @(negedge clk);
        width++;
      end
      check("blink_half_period", width, BL);
    end

    // Timeout in the minutes field keeps the partial edit and never commits.
    do_reset();
    set_cur(0, 7, 15);
    p0 = prop_cnt;
    press(1, 0, 0, 1, 3);
    press(0, 1, 0, 1, 3);
    press(1, 0, 0, 1, 3);
    repeat (10) @(negedge clk);
    check("to_still_editing", int'(editing), 1);
    check("to_still_field", int'(edit_field), 2);
    repeat (15) @(negedge clk);
    check("to_editing", int'(editing), 0);
    check("to_field", int'(edit_field), 0);
    check("to_blink", int'(blink), 0);
    check("to_no_prop", prop_cnt - p0, 0);
    check("to_hours_kept", int'(out_hours), 8);
    check("to_minutes_kept", int'(out_minutes), 15);

    // Holding up for 30 cycles in the minutes field starting at 5.
    do_reset();
    set_cur(0, 3, 5);
    press(1, 0, 0, 1, 3);
    press(1, 0, 0, 1, 3);
    press(0, 1, 0, 30, 3);
`ifdef AUTO_REPEAT_EN
    check("hold_up_minutes", int'(out_minutes), 11);
    check("hold_up_field", int'(edit_field), 2);
`else
    check("hold_up_minutes", int'(out_minutes), 6);
`endif

    // Randomized presses against the field-level model.
    do_reset();
    mf = 0; mh = 0; mm = 0; mpm = 0;
    exp_prop = prop_cnt;
    for (int n = 0; n < 300; n++) begin
      int r;
      bit m, u, d;
      r = int'($urandom_range(0, 9));
      m = (r <= 2) || (r == 9);
      u = (r >= 3 && r <= 5) || (r == 8) || (r == 9 && $urandom_range(0, 1) == 1);
      d = (r == 6) || (r == 7) || (r == 8);
      set_cur(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)), int'($urandom_range(0, 63)));
      model_press(m, u, d);
      press(m, u, d, int'($urandom_range(1, 3)), int'($urandom_range(2, 4)));
      check($sformatf("rnd%0d_field", n), int'(edit_field), mf);
      check($sformatf("rnd%0d_hours", n), int'(out_hours), mh);
      check($sformatf("rnd%0d_minutes", n), int'(out_minutes), mm);
      check($sformatf("rnd%0d_pm", n), int'(out_PM), mpm);
      check($sformatf("rnd%0d_props", n), prop_cnt, exp_prop);
      if (m && mf == 0 && prop_cnt == exp_prop) begin
        check($sformatf("rnd%0d_cap_h", n), cap_h, mh);
        check($sformatf("rnd%0d_cap_m", n), cap_m, mm);
        check($sformatf("rnd%0d_cap_pm", n), cap_pm, mpm);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
